// File: rtl/tx_frame_sequencer_pkg.sv
// Shared types and constants for the single-transmitter frame sequencer.
// Frame byte order is header, A, B, checksum, addressed by a 2-bit index.
package tx_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_END = 3'd3,
    ST_NEXT     = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    HS_IDLE  = 2'd0,
    HS_ISSUE = 2'd1,
    HS_WAIT  = 2'd2
  } hs_state_e;

  localparam logic [1:0] IDX_HDR = 2'd0;
  localparam logic [1:0] IDX_A   = 2'd1;
  localparam logic [1:0] IDX_B   = 2'd2;
  localparam logic [1:0] IDX_CHK = 2'd3;

  localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;

endpackage

// File: rtl/tx_frame_sequencer_handshake.sv
// One-byte start/active handshake with the UART transmitter, plus the
// acknowledge timeout. Byte is latched when go is first seen.
module tx_byte_handshake
  import tx_frame_sequencer_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              divClk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] byte_in,
  input  logic              tx_active,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              byte_done,
  output logic              timeout
);

  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

  hs_state_e         hs_q, hs_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_inc;

  always_ff @(posedge divClk or posedge rst) begin
    if (rst) begin
      hs_q       <= HS_IDLE;
      tx_start_q <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      hs_q       <= hs_d;
      tx_start_q <= tx_start_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    hs_d       = hs_q;
    tx_start_d = tx_start_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    byte_done  = 1'b0;
    timeout    = 1'b0;
    cnt_inc    = cnt_q + 8'd1;
    case (hs_q)
      HS_IDLE: begin
        if (go) begin
          tx_start_d = 1'b1;
          data_d     = byte_in;
          cnt_d      = '0;
          hs_d       = HS_ISSUE;
        end
      end
      HS_ISSUE: begin
        // An acknowledge in the final cycle still wins over the timeout.
        if (tx_active) begin
          tx_start_d = 1'b0;
          cnt_d      = '0;
          hs_d       = HS_WAIT;
        end else if (cnt_inc == TMO) begin
          timeout    = 1'b1;
          tx_start_d = 1'b0;
          cnt_d      = '0;
          hs_d       = HS_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HS_WAIT: begin
        if (!tx_active) begin
          byte_done = 1'b1;
          hs_d      = HS_IDLE;
        end
      end
      default: hs_d = HS_IDLE;
    endcase
  end

  assign tx_start = tx_start_q;
  assign tx_data  = data_q;

endmodule

// File: rtl/tx_frame_sequencer.sv
// Sends snapshot numbers A and B as one framed transfer over a single UART
// transmitter: optional header, A, B, XOR checksum. One request may queue.
module tx_frame_sequencer
  import tx_frame_sequencer_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                HDR_EN      = 1,
  parameter logic [DATA_W-1:0] HDR_BYTE    = DATA_W'(DEF_HDR_BYTE),
  parameter int                ACK_TIMEOUT = 255
) (
  input  logic              divClk,
  input  logic              rst,
  input  logic              send_req,
  input  logic [DATA_W-1:0] num_a,
  input  logic [DATA_W-1:0] num_b,
  input  logic              tx_active,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_timeout
);

  state_e            state_q, state_d;
  logic              send_req_q, send_req_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic [1:0]        idx_q, idx_d;
  logic              start;
  logic [DATA_W-1:0] cur_byte;
  logic              hs_byte_done;
  logic              hs_timeout;

  always_ff @(posedge divClk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      send_req_q <= 1'b0;
      pending_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      chk_q      <= '0;
      idx_q      <= IDX_HDR;
    end else begin
      state_q    <= state_d;
      send_req_q <= send_req_d;
      pending_q  <= pending_d;
      a_q        <= a_d;
      b_q        <= b_d;
      chk_q      <= chk_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    send_req_d = send_req;
    start      = send_req & ~send_req_q;
    state_d    = state_q;
    pending_d  = pending_q;
    a_d        = a_q;
    b_d        = b_q;
    chk_d      = chk_q;
    idx_d      = idx_q;
    // Any start seen while a frame runs (including DONE) becomes the one queued frame.
    if (state_q != ST_IDLE && start) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start || pending_q) begin
          pending_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        a_d     = num_a;
        b_d     = num_b;
        chk_d   = num_a ^ num_b ^ ((HDR_EN != 0) ? HDR_BYTE : '0);
        idx_d   = (HDR_EN != 0) ? IDX_HDR : IDX_A;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (hs_timeout)                state_d = ST_IDLE;
        else if (tx_start & tx_active) state_d = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        if (hs_byte_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q == IDX_CHK) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      IDX_HDR: cur_byte = HDR_BYTE;
      IDX_A:   cur_byte = a_q;
      IDX_B:   cur_byte = b_q;
      default: cur_byte = chk_q;
    endcase
  end

  tx_byte_handshake #(
    .DATA_W     (DATA_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_hs (
    .divClk   (divClk),
    .rst      (rst),
    .go       (state_q == ST_ISSUE),
    .byte_in  (cur_byte),
    .tx_active(tx_active),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .byte_done(hs_byte_done),
    .timeout  (hs_timeout)
  );

  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = (state_q == ST_DONE);
  assign err_timeout = hs_timeout;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: a behavioural transmitter acknowledges each
// tx_start and checks the byte against a queue of expected frame bytes.
module tb_tx_frame_sequencer;

  localparam int ACK_DLY  = 2;
  localparam int ACT_HOLD = 20;

  logic       divClk = 1'b0;
  logic       rst;
  logic [1:0] send_req;
  logic [7:0] num_a, num_b;
  logic [1:0] tx_active = 2'b00;
  logic [1:0] tx_start, busy, frame_done, err_timeout;
  logic [7:0] tx_data_v [2];
  logic [1:0] dead;

  int checks   = 0;
  int failures = 0;
  int wait_cnt [2];
  int act_cnt  [2];
  int hs_cnt   [2];
  int fd_cnt   [2];
  int err_cnt  [2];
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;

  always #5 divClk = ~divClk;

  // Index 0: no header; index 1: header enabled.
  tx_frame_sequencer #(.HDR_EN(0)) dut_nohdr (
    .divClk(divClk), .rst(rst), .send_req(send_req[0]), .num_a(num_a), .num_b(num_b),
    .tx_active(tx_active[0]), .tx_start(tx_start[0]), .tx_data(tx_data_v[0]),
    .busy(busy[0]), .frame_done(frame_done[0]), .err_timeout(err_timeout[0])
  );

  tx_frame_sequencer #(.HDR_EN(1)) dut (
    .divClk(divClk), .rst(rst), .send_req(send_req[1]), .num_a(num_a), .num_b(num_b),
    .tx_active(tx_active[1]), .tx_start(tx_start[1]), .tx_data(tx_data_v[1]),
    .busy(busy[1]), .frame_done(frame_done[1]), .err_timeout(err_timeout[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: acknowledges ACK_DLY cycles after tx_start, busy for ACT_HOLD.
  always @(negedge divClk) begin
    for (int i = 0; i < 2; i++) begin
      if (frame_done[i])  fd_cnt[i]++;
      if (err_timeout[i]) err_cnt[i]++;
      if (act_cnt[i] > 0) begin
        act_cnt[i]--;
        if (act_cnt[i] == 0) tx_active[i] = 1'b0;
      end else if (tx_start[i] && !dead[i]) begin
        wait_cnt[i]++;
        if (wait_cnt[i] == ACK_DLY) begin
          wait_cnt[i]  = 0;
          tx_active[i] = 1'b1;
          act_cnt[i]   = ACT_HOLD;
          hs_cnt[i]++;
          if (exp_q.size() == 0) begin
            check("byte_unexpected", {24'd0, tx_data_v[i]}, 32'hFFFF_FFFF);
          end else begin
            exp_b = exp_q.pop_front();
            check("byte", {24'd0, tx_data_v[i]}, {24'd0, exp_b});
          end
        end
      end else begin
        wait_cnt[i] = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge divClk);
  endtask

  task automatic pulse(input int i);
    send_req[i] = 1'b1;
    cyc(1);
    send_req[i] = 1'b0;
  endtask

  task automatic push_frame(input logic hdr, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] h;
    h = hdr ? 8'hA5 : 8'h00;
    if (hdr) exp_q.push_back(8'hA5);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(a ^ b ^ h);
  endtask

  task automatic wait_fd(input int i, input int target, input int budget);
    for (int n = 0; n < budget && fd_cnt[i] < target; n++) cyc(1);
  endtask

  initial begin
    int hs0, fd0, er0, start_hi, err_seen, fd_seen;
    rst = 1'b1; send_req = 2'b00; num_a = 8'd0; num_b = 8'd0; dead = 2'b00;
    cyc(2);
    check("rst_tx_start", {30'd0, tx_start}, 32'd0);
    check("rst_busy", {30'd0, busy}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data_v[1]}, 32'd0);
    check("rst_frame_done", {30'd0, frame_done}, 32'd0);
    check("rst_err", {30'd0, err_timeout}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // Basic frame with header
    num_a = 8'd42; num_b = 8'd7;
    hs0 = hs_cnt[1]; fd0 = fd_cnt[1];
    push_frame(1'b1, 8'd42, 8'd7);
    pulse(1);
    check("basic_busy_hi", {31'd0, busy[1]}, 32'd1);
    wait_fd(1, fd0 + 1, 1000);
    cyc(3);
    check("basic_hs", hs_cnt[1] - hs0, 32'd4);
    check("basic_fd", fd_cnt[1] - fd0, 32'd1);
    check("basic_busy_lo", {31'd0, busy[1]}, 32'd0);
    check("basic_q_empty", exp_q.size(), 32'd0);

    // No header
    num_a = 8'd99; num_b = 8'd0;
    hs0 = hs_cnt[0]; fd0 = fd_cnt[0];
    exp_q.push_back(8'h63); exp_q.push_back(8'h00); exp_q.push_back(8'h63);
    pulse(0);
    wait_fd(0, fd0 + 1, 1000);
    cyc(3);
    check("nohdr_hs", hs_cnt[0] - hs0, 32'd3);
    check("nohdr_fd", fd_cnt[0] - fd0, 32'd1);
    check("nohdr_busy_lo", {31'd0, busy[0]}, 32'd0);
    check("nohdr_q_empty", exp_q.size(), 32'd0);

    // Snapshot and single-entry queue
    num_a = 8'd42; num_b = 8'd7;
    hs0 = hs_cnt[1]; fd0 = fd_cnt[1];
    push_frame(1'b1, 8'd42, 8'd7);
    push_frame(1'b1, 8'd10, 8'd7);
    pulse(1);
    cyc(10);
    num_a = 8'd10;
    pulse(1);
    cyc(4);
    pulse(1);
    check("queue_busy", {31'd0, busy[1]}, 32'd1);
    wait_fd(1, fd0 + 2, 2000);
    cyc(5);
    check("queue_fd", fd_cnt[1] - fd0, 32'd2);
    check("queue_busy_lo", {31'd0, busy[1]}, 32'd0);
    cyc(300);
    check("queue_third_lost_hs", hs_cnt[1] - hs0, 32'd8);
    check("queue_third_lost_fd", fd_cnt[1] - fd0, 32'd2);
    check("queue_q_empty", exp_q.size(), 32'd0);

    // Acknowledge timeout
    dead[1] = 1'b1;
    hs0 = hs_cnt[1]; fd0 = fd_cnt[1]; er0 = err_cnt[1];
    start_hi = 0; err_seen = 0; fd_seen = 0;
    pulse(1);
    for (int n = 0; n < 400; n++) begin
      if (tx_start[1])    start_hi++;
      if (err_timeout[1]) err_seen++;
      if (frame_done[1])  fd_seen++;
      cyc(1);
    end
    check("tmo_start_cycles", start_hi, 32'd255);
    check("tmo_err_pulses", err_seen, 32'd1);
    check("tmo_no_done", fd_seen, 32'd0);
    check("tmo_busy_lo", {31'd0, busy[1]}, 32'd0);
    check("tmo_no_hs", hs_cnt[1] - hs0, 32'd0);
    dead[1] = 1'b0;

    // Asynchronous reset during WAIT_END of byte B
    num_a = 8'd42; num_b = 8'd7;
    hs0 = hs_cnt[1];
    exp_q.push_back(8'hA5); exp_q.push_back(8'd42); exp_q.push_back(8'd7);
    pulse(1);
    for (int n = 0; n < 1000 && hs_cnt[1] < hs0 + 3; n++) cyc(1);
    check("rstmid_reached_b", hs_cnt[1] - hs0, 32'd3);
    cyc(3);
    check("rstmid_busy_before", {31'd0, busy[1]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_tx_start", {31'd0, tx_start[1]}, 32'd0);
    check("rstmid_busy", {31'd0, busy[1]}, 32'd0);
    check("rstmid_tx_data", {24'd0, tx_data_v[1]}, 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(25);
    check("rstmid_q_empty", exp_q.size(), 32'd0);
    hs0 = hs_cnt[1]; fd0 = fd_cnt[1];
    push_frame(1'b1, 8'd42, 8'd7);
    pulse(1);
    wait_fd(1, fd0 + 1, 1000);
    cyc(3);
    check("rstmid_fresh_hs", hs_cnt[1] - hs0, 32'd4);
    check("rstmid_fresh_fd", fd_cnt[1] - fd0, 32'd1);

    // Level held high sends exactly one frame
    hs0 = hs_cnt[1]; fd0 = fd_cnt[1];
    push_frame(1'b1, 8'd42, 8'd7);
    send_req[1] = 1'b1;
    cyc(500);
    check("level_busy_lo", {31'd0, busy[1]}, 32'd0);
    send_req[1] = 1'b0;
    cyc(20);
    check("level_hs", hs_cnt[1] - hs0, 32'd4);
    check("level_fd", fd_cnt[1] - fd0, 32'd1);
    check("level_q_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
